an29_frame_scheduler: RTL and testbench



---
 rtl/an29_pkg.sv | 29 ++
 rtl/an29_barrett_lane.sv | 94 +++++++++
 rtl/an29_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_an29_frame_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/an29_pkg.sv
// Shared constants and types for the AN (A=29) frame scheduler and its Barrett lane.
package an29_pkg;

  localparam int unsigned FRAME_LEN = 25;
  localparam int unsigned A_CODE    = 29;
  localparam int unsigned BARRETT_K = 18;
  localparam int unsigned BARRETT_M = 9039;

  localparam int unsigned CODE_W   = 14;
  localparam int unsigned PROD_W   = 28;  // 14-bit code times 14-bit Barrett constant
  localparam int unsigned QUOT_W   = 10;  // largest quotient is 16383 / 29 = 564
  localparam int unsigned DATA_W   = 5;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned ERRCNT_W = 5;
  localparam int unsigned DATA_MAX = (1 << DATA_W) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              last;
  } result_t;

endpackage

// File: rtl/an29_barrett_lane.sv
// Two-stage pipelined Barrett reduction by A_CODE with valid/last sideband.
// No backpressure: the caller guarantees every result has somewhere to go.
module an29_barrett_lane
  import an29_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              last_o,
  output logic [1:0]        inflight_o
);

  logic              s1_valid_d, s1_valid_q;
  logic              s1_last_d, s1_last_q;
  logic [CODE_W-1:0] s1_code_d, s1_code_q;
  logic [QUOT_W-1:0] s1_qest_d, s1_qest_q;

  logic              s2_valid_d, s2_valid_q;
  logic              s2_last_d, s2_last_q;
  logic [DATA_W-1:0] s2_data_d, s2_data_q;
  logic              s2_err_d, s2_err_q;

  logic [PROD_W-1:0] prod;
  logic [CODE_W-1:0] qa;
  logic [CODE_W-1:0] rem;
  logic [QUOT_W-1:0] quot;

  // Stage 1: quotient estimate, never above the true quotient and at most one below it.
  always_comb begin
    prod       = PROD_W'(code_i) * PROD_W'(BARRETT_M);
    s1_valid_d = valid_i;
    s1_last_d  = last_i;
    s1_code_d  = code_i;
    s1_qest_d  = QUOT_W'(prod >> BARRETT_K);
  end

  // Stage 2: remainder, single correction step, then saturation and error flag.
  always_comb begin
    qa   = CODE_W'(s1_qest_q) * CODE_W'(A_CODE);
    rem  = s1_code_q - qa;
    quot = s1_qest_q;
    if (rem >= CODE_W'(A_CODE)) begin
      quot = s1_qest_q + QUOT_W'(1);
      rem  = rem - CODE_W'(A_CODE);
    end
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;
    if (quot > QUOT_W'(DATA_MAX)) begin
      s2_data_d = DATA_W'(DATA_MAX);
      s2_err_d  = 1'b1;
    end else begin
      s2_data_d = quot[DATA_W-1:0];
      s2_err_d  = (rem != '0);
    end
  end

  // Pipeline registers; only the valid bits matter after reset but all are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_code_q  <= '0;
      s1_qest_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_code_q  <= s1_code_d;
      s1_qest_q  <= s1_qest_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

  // Lane outputs and in-flight count for the scheduler's credit check.
  always_comb begin
    valid_o    = s2_valid_q;
    data_o     = s2_data_q;
    err_o      = s2_err_q;
    last_o     = s2_last_q;
    inflight_o = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
  end

endmodule

// File: rtl/an29_frame_scheduler.sv
// Frame scheduler: feeds 25-codeword frames through one shared Barrett lane,
// buffers results in a credit-protected skid FIFO and reports per-frame errors.
module an29_frame_scheduler
  import an29_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_data,
  output logic        out_err,
  output logic        out_last,
  output logic        frame_done,
  output logic [4:0]  frame_err_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  state_e              state_d, state_q;
  logic [IDX_W-1:0]    idx_d, idx_q;
  logic [ERRCNT_W-1:0] err_cnt_d, err_cnt_q;
  logic [ERRCNT_W-1:0] frame_err_cnt_d, frame_err_cnt_q;
  logic                frame_done_d, frame_done_q;

  result_t             mem_d [FIFO_DEPTH];
  result_t             mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]     cnt_d, cnt_q;

  logic                lane_valid;
  logic [DATA_W-1:0]   lane_data;
  logic                lane_err;
  logic                lane_last;
  logic [1:0]          lane_inflight;

  logic                accept;
  logic                is_last_word;
  logic                credit;
  logic [OccW-1:0]     occ;
  logic                push;
  logic                pop;
  result_t             head;

  an29_barrett_lane u_lane (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (accept),
    .last_i     (is_last_word),
    .code_i     (in_code),
    .valid_o    (lane_valid),
    .data_o     (lane_data),
    .err_o      (lane_err),
    .last_o     (lane_last),
    .inflight_o (lane_inflight)
  );

  // Handshakes and credit: in-flight plus buffered results may never exceed the FIFO.
  always_comb begin
    occ          = OccW'(lane_inflight) + OccW'(cnt_q);
    credit       = (occ < OccW'(FIFO_DEPTH));
    in_ready     = rst_n & credit & (state_q != StDrain);
    accept       = in_valid & in_ready;
    is_last_word = (idx_q == IDX_W'(FRAME_LEN - 1));
    head         = mem_q[rd_ptr_q];
    out_valid    = (cnt_q != '0);
    pop          = out_valid & out_ready;
    push         = lane_valid;
  end

  // Result FIFO next state; push and pop in the same cycle keep occupancy unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: lane_data, err: lane_err, last: lane_last};
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame FSM, word index and error accounting.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    err_cnt_d       = err_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;
    frame_done_d    = 1'b0;

    if (accept) begin
      idx_d = is_last_word ? '0 : idx_q + IDX_W'(1);
    end

    if (pop) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(head.err);
      if (head.last) begin
        // Close the frame; the running count restarts for the next one.
        frame_done_d    = 1'b1;
        frame_err_cnt_d = err_cnt_q + ERRCNT_W'(head.err);
        err_cnt_d       = '0;
      end
    end

    unique case (state_q)
      StIdle:  if (accept) state_d = is_last_word ? StDrain : StRun;
      StRun:   if (accept && is_last_word) state_d = StDrain;
      StDrain: if (pop && head.last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Result outputs are forced to zero whenever nothing is being presented.
  always_comb begin
    out_data      = out_valid ? head.data : '0;
    out_err       = out_valid & head.err;
    out_last      = out_valid & head.last;
    frame_done    = frame_done_q;
    frame_err_cnt = frame_err_cnt_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      err_cnt_q       <= '0;
      frame_err_cnt_q <= '0;
      frame_done_q    <= 1'b0;
      mem_q           <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      err_cnt_q       <= err_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
      frame_done_q    <= frame_done_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
    end
  end

endmodule

// File: tb/tb_an29_frame_scheduler.sv
// Self-checking bench for an29_frame_scheduler: randomized frames against a
// division-based reference model and a result scoreboard.
module tb_an29_frame_scheduler;

  localparam int FRAME = 25;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0] data;
    logic       err;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_data;
  logic        out_err;
  logic        out_last;
  logic        frame_done;
  logic [4:0]  frame_err_cnt;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  exp_t exp_q[$];
  int   m_idx = 0, outst = 0, m_err = 0, m_ferr = 0, pf = 0;
  bit   m_drain = 0, m_fd = 0, prev_stall = 0, saw_drop = 0;
  logic [4:0] prev_data;
  logic prev_err, prev_last;
  int   gap_cnt = 0, n_pop = 0, fd_cnt = 0;
  int   pop_at_fd[$];
  int   first_acc = -1, first_out = -1;
  int   rdy_mode = 0;
  int   frame_codes[FRAME];

  an29_frame_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err       (out_err),
    .out_last      (out_last),
    .frame_done    (frame_done),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference decode straight from the code definition: quotient and remainder by 29.
  function automatic exp_t ref_word(input int code);
    exp_t e;
    int q, r;
    q = code / 29;
    r = code % 29;
    e.data = (q > 31) ? 5'd31 : 5'(q);
    e.err  = (r != 0) || (q > 31);
    e.last = 1'b0;
    return e;
  endfunction

  function automatic int rand_code();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 16383));
    return int'($urandom_range(0, 35)) * 29 +
           (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 28)) : 0);
  endfunction

  // Scoreboard monitor: checks at the negedge, then applies the coming edge's handshakes.
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!rst_n) begin
      check_eq("rst_in_ready", 32'(in_ready), 0);
      exp_q.delete();
      m_idx = 0; outst = 0; m_err = 0; m_ferr = 0; pf = 0;
      m_drain = 0; m_fd = 0; prev_stall = 0;
      first_acc = -1; first_out = -1;
    end else begin
      check_eq("in_ready", 32'(in_ready), 32'(!m_drain && outst < DEPTH));
      check_eq("frame_done", 32'(frame_done), 32'(m_fd));
      check_eq("frame_err_cnt", 32'(frame_err_cnt), 32'(m_ferr));
      if (prev_stall) begin
        check_eq("stall_valid", 32'(out_valid), 1);
        check_eq("stall_data", 32'(out_data), 32'(prev_data));
        check_eq("stall_err", 32'(out_err), 32'(prev_err));
        check_eq("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (first_out < 0 && out_valid) first_out = cyc;
      if (frame_done) begin
        fd_cnt++;
        pop_at_fd.push_back(n_pop);
      end
      if (pf > 0 && !out_valid) gap_cnt++;
      if (rdy_mode == 2 && in_valid && !in_ready) saw_drop = 1;

      m_fd = 0;
      if (out_valid && out_ready) begin
        n_pop++;
        outst--;
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", 32'(out_data), 32'(e.data));
          check_eq("out_err", 32'(out_err), 32'(e.err));
          check_eq("out_last", 32'(out_last), 32'(e.last));
          if (e.err) m_err++;
          pf++;
          if (e.last) begin
            m_fd = 1; m_ferr = m_err; m_err = 0; m_drain = 0; pf = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = ref_word(int'(in_code));
        e.last = (m_idx == FRAME - 1);
        exp_q.push_back(e);
        outst++;
        if (first_acc < 0) first_acc = cyc;
        if (e.last) begin
          m_drain = 1; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
      prev_last  = out_last;
    end
  end

  // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_word(input int code, input int gap);
    int budget;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_code  = 14'(code);
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready || budget >= 300) break;
      budget++;
    end
    if (!in_ready) check_eq("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < FRAME; i++) begin
      send_word(frame_codes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || m_drain) && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd0, p0, cnt;
    bit mark[FRAME];

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_err", 32'(out_err), 0);
    check_eq("rst_out_last", 32'(out_last), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_frame_err_cnt", 32'(frame_err_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean frame k*29.
    for (int k = 0; k < FRAME; k++) frame_codes[k] = k * 29;
    send_frame(0);
    wait_idle();
    check_eq("latency", 32'(first_out - first_acc), 3);
    check_eq("clean_err_cnt", 32'(frame_err_cnt), 0);
    check_eq("clean_fd_count", 32'(fd_cnt), 1);

    // Error and boundary words.
    for (int k = 0; k < FRAME; k++) frame_codes[k] = rand_code();
    frame_codes[0] = 146;
    frame_codes[1] = 899;
    frame_codes[2] = 928;
    frame_codes[3] = 16383;
    send_frame(0);
    wait_idle();

    // Backpressure: 20 stalled cycles mid-frame.
    for (int k = 0; k < FRAME; k++) frame_codes[k] = rand_code();
    saw_drop = 0;
    fork
      send_frame(0);
      begin
        repeat (6) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (20) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    wait_idle();
    check_eq("bp_ready_drop", 32'(saw_drop), 1);

    // Exactly seven erroneous words, then a clean frame.
    for (int k = 0; k < FRAME; k++) begin
      frame_codes[k] = int'($urandom_range(0, 31)) * 29;
      mark[k] = 0;
    end
    cnt = 0;
    while (cnt < 7) begin
      int p;
      p = int'($urandom_range(0, FRAME - 1));
      if (!mark[p]) begin
        mark[p] = 1;
        frame_codes[p] = frame_codes[p] + 1;
        cnt++;
      end
    end
    send_frame(0);
    wait_idle();
    check_eq("err_cnt_7", 32'(frame_err_cnt), 7);
    for (int k = 0; k < FRAME; k++) frame_codes[k] = int'($urandom_range(0, 31)) * 29;
    send_frame(0);
    wait_idle();
    check_eq("err_cnt_next", 32'(frame_err_cnt), 0);

    // Back-to-back frames with continuous input.
    gap_cnt = 0;
    fd0 = fd_cnt;
    p0  = n_pop;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < FRAME; k++) frame_codes[k] = rand_code();
      send_frame(0);
    end
    wait_idle();
    check_eq("b2b_results", 32'(n_pop - p0), 50);
    check_eq("b2b_fd_pulses", 32'(fd_cnt - fd0), 2);
    if (pop_at_fd.size() >= 2)
      check_eq("b2b_fd_spacing",
               32'(pop_at_fd[pop_at_fd.size() - 1] - pop_at_fd[pop_at_fd.size() - 2]), 25);
    check_eq("b2b_gaps", 32'(gap_cnt), 0);

    // Random gaps and random downstream ready.
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < FRAME; k++) frame_codes[k] = rand_code();
      send_frame(3);
    end
    rdy_mode = 0;
    wait_idle();

    // One-cycle reset with word 12 just issued to the lane.
    for (int k = 0; k < 13; k++) send_word(k * 29 + 1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_out_valid", 32'(out_valid), 0);
    check_eq("mid_rst_out_data", 32'(out_data), 0);
    check_eq("mid_rst_out_err", 32'(out_err), 0);
    check_eq("mid_rst_out_last", 32'(out_last), 0);
    check_eq("mid_rst_frame_done", 32'(frame_done), 0);
    check_eq("mid_rst_frame_err_cnt", 32'(frame_err_cnt), 0);
    @(posedge clk);
    #1;
    fd0 = fd_cnt;
    for (int k = 0; k < FRAME; k++) frame_codes[k] = k * 29;
    send_frame(0);
    wait_idle();
    check_eq("post_rst_fd", 32'(fd_cnt - fd0), 1);
    check_eq("post_rst_err_cnt", 32'(frame_err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
